// File: rtl/dl_shift_seq_if.sv
// rtl/dl_shift_seq_if.sv - request/response handshake bundle for the shift sequencer
interface dl_shift_seq_if #(
  parameter int NUM_BITS = 32
) ();
  localparam int SHAMT_BITS = $clog2(NUM_BITS);

  logic                  req_valid;
  logic                  req_ready;
  logic [NUM_BITS-1:0]   req_a;
  logic [SHAMT_BITS-1:0] req_shamt;
  logic [1:0]            req_op;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [NUM_BITS-1:0]   resp_data;

  modport master (
    output req_valid, req_a, req_shamt, req_op, resp_ready,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_a, req_shamt, req_op, resp_ready,
    output req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/dl_shift_seq.sv
// rtl/dl_shift_seq.sv - multi-cycle shift sequencer using a narrow per-cycle step shifter
module dl_shift_seq #(
  parameter int NUM_BITS  = 32,
  parameter int STEP_BITS = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  output logic         busy,
  dl_shift_seq_if.slave bus
);
  localparam int SHAMT_BITS = $clog2(NUM_BITS);
  localparam int MAX_STEP   = (2 ** STEP_BITS) - 1;
  localparam logic [SHAMT_BITS-1:0] MAX_STEP_W = SHAMT_BITS'(MAX_STEP);

  localparam logic [1:0] OP_SRL = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t                state, state_nxt;
  logic [NUM_BITS-1:0]   data, data_shf;
  logic [1:0]            op;
  logic [SHAMT_BITS-1:0] rem, rem_nxt, step;
  logic                  accept;

  assign bus.req_ready  = (state == IDLE) && !flush;
  assign accept         = bus.req_valid && bus.req_ready;
  assign bus.resp_valid = (state == DONE);
  assign bus.resp_data  = data;
  assign busy           = (state != IDLE);

  assign step    = (rem > MAX_STEP_W) ? MAX_STEP_W : rem;
  assign rem_nxt = rem - step;

  // SRA keeps replicating data's MSB, which is the sign latched at acceptance.
  always_comb begin
    data_shf = data >> step;
    case (op)
      OP_SLL:  data_shf = data << step;
      OP_SRA:  data_shf = NUM_BITS'($signed(data) >>> step);
      default: data_shf = data >> step;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (bus.req_shamt == '0) ? DONE : SHIFT;
      SHIFT:   if (rem_nxt == '0) state_nxt = DONE;
      DONE:    if (bus.resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
      op   <= OP_SRL;
      rem  <= '0;
    end else if (flush) begin
      rem <= '0;
    end else if (accept) begin
      data <= bus.req_a;
      op   <= (bus.req_op == 2'b11) ? OP_SRL : bus.req_op;
      rem  <= bus.req_shamt;
    end else if (state == SHIFT) begin
      data <= data_shf;
      rem  <= rem_nxt;
    end
  end
endmodule

// File: tb/tb_dl_shift_seq.sv
// tb/tb_dl_shift_seq.sv - scoreboard bench for dl_shift_seq with a behavioural shift model
module tb_dl_shift_seq;
  logic clk;
  logic rst_n;
  logic flush;
  logic busy;
  int   cyc;
  int   checks;
  int   errors;
  int   rr_mode;
  logic rr_val;
  logic rr_rand;

  typedef struct {
    logic [31:0] data;
    int          lat;
    int          acc;
  } exp_t;
  exp_t q[$];

  dl_shift_seq_if #(.NUM_BITS(32)) bus ();

  dl_shift_seq #(.NUM_BITS(32), .STEP_BITS(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .busy  (busy),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) rr_rand <= 1'($urandom_range(0, 1));
  assign bus.resp_ready = (rr_mode == 2) ? rr_val : ((rr_mode == 1) ? rr_rand : 1'b1);

  function automatic logic [31:0] model(input logic [31:0] a, input int s, input logic [1:0] op);
    case (op)
      2'b01:   return a << s;
      2'b10:   return 32'($signed(a) >>> s);
      default: return a >> s;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the acceptance edge.
  task automatic do_req(input logic [31:0] a, input int s, input logic [1:0] op, output int acc);
    int   n;
    exp_t e;
    n = 0;
    bus.req_a     = a;
    bus.req_shamt = 5'(s);
    bus.req_op    = op;
    bus.req_valid = 1'b1;
    while (!bus.req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      chk("accept_timeout", 32'(n), 32'(0));
      bus.req_valid = 1'b0;
      acc = -1;
      return;
    end
    e.data = model(a, s, op);
    e.lat  = (s + 2) / 3 + 1;
    e.acc  = cyc + 1;
    acc    = e.acc;
    q.push_back(e);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_a     = $urandom;
    bus.req_shamt = 5'($urandom);
    bus.req_op    = 2'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q.size() != 0 || busy) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("idle_timeout", 32'(n), 32'(0));
    @(negedge clk);
  endtask

  logic        in_resp;
  logic [31:0] held;
  initial in_resp = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    #1;
    if (!rst_n) begin
      in_resp = 1'b0;
    end else begin
      chk("req_ready_rule", 32'(bus.req_ready), 32'(!busy && !flush));
      if (bus.resp_valid) begin
        if (!in_resp) begin
          in_resp = 1'b1;
          held    = bus.resp_data;
          chk("busy_in_done", 32'(busy), 32'(1));
          if (q.size() == 0) begin
            chk("unexpected_resp", 32'(bus.resp_valid), 32'(0));
          end else begin
            e = q.pop_front();
            chk("resp_data", bus.resp_data, e.data);
            chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
          end
        end else begin
          chk("resp_stable", bus.resp_data, held);
        end
      end else begin
        in_resp = 1'b0;
      end
    end
  end

  initial begin
    int acc;
    int hs;
    int n;
    checks = 0;
    errors = 0;
    rr_mode = 0;
    rr_val = 1'b0;
    rst_n = 1'b0;
    flush = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_a = '0;
    bus.req_shamt = '0;
    bus.req_op = '0;

    @(negedge clk);
    #1;
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_req_ready", 32'(bus.req_ready), 32'(1));
    chk("rst_resp_data", bus.resp_data, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    do_req(32'h8000_0000, 31, 2'b00, acc); wait_idle();
    do_req(32'hF000_0000, 4, 2'b10, acc);  wait_idle();
    do_req(32'h7000_0000, 4, 2'b10, acc);  wait_idle();
    do_req(32'h0000_0001, 5, 2'b01, acc);  wait_idle();
    do_req(32'h1234_5678, 0, 2'b11, acc);  wait_idle();
    do_req(32'h1234_5678, 8, 2'b11, acc);  wait_idle();
    do_req(32'h8000_0001, 31, 2'b10, acc); wait_idle();
    do_req(32'h8000_0001, 31, 2'b01, acc); wait_idle();

    // Backpressure in DONE with a new request already waiting.
    rr_mode = 2;
    rr_val  = 1'b0;
    do_req(32'hF000_0000, 4, 2'b10, acc);
    n = 0;
    while (!bus.resp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("bp_resp_timeout", 32'(n), 32'(0));
    bus.req_a     = 32'h0000_0001;
    bus.req_shamt = 5'd5;
    bus.req_op    = 2'b01;
    bus.req_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_resp_valid", 32'(bus.resp_valid), 32'(1));
      chk("bp_req_ready", 32'(bus.req_ready), 32'(0));
      chk("bp_resp_data", bus.resp_data, 32'hFF00_0000);
    end
    rr_val = 1'b1;
    hs = cyc + 1;
    @(negedge clk);
    rr_val  = 1'b0;
    rr_mode = 0;
    do_req(32'h0000_0001, 5, 2'b01, acc);
    chk("bp_accept_gap", 32'(acc), 32'(hs + 1));
    wait_idle();

    // Flush on the second SHIFT cycle drops the operation.
    do_req(32'hDEAD_BEEF, 31, 2'b00, acc);
    @(negedge clk);
    flush = 1'b1;
    q.delete();
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", 32'(busy), 32'(0));
    chk("flush_resp_valid", 32'(bus.resp_valid), 32'(0));
    repeat (15) @(negedge clk);

    // Flush in IDLE blocks acceptance.
    bus.req_valid = 1'b1;
    flush = 1'b1;
    #1;
    chk("flush_idle_ready", 32'(bus.req_ready), 32'(0));
    @(negedge clk);
    chk("flush_idle_noacc", 32'(busy), 32'(0));
    bus.req_valid = 1'b0;
    flush = 1'b0;
    @(negedge clk);

    // Asynchronous reset mid-SHIFT.
    do_req(32'hCAFE_F00D, 31, 2'b10, acc);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("arst_resp_valid", 32'(bus.resp_valid), 32'(0));
    chk("arst_busy", 32'(busy), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("arst_req_ready", 32'(bus.req_ready), 32'(1));
    @(negedge clk);

    // Randomized sweep with random consumer backpressure.
    rr_mode = 1;
    for (int op = 0; op < 4; op++) begin
      for (int s = 0; s < 32; s++) begin
        do_req($urandom, s, 2'(op), acc);
        wait_idle();
      end
    end
    rr_mode = 0;
    wait_idle();
    if (q.size() != 0) chk("leftover_expect", 32'(q.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
